ir_cmd_queue: RTL and testbench
===============================

# ir_cmd_queue

Parametrised command capture stage between `ir_receiver` and its consumers (`led_mgr`, `command_display`). Replaces the single-register edge capture with a rising-edge detector, an optional auto-repeat filter, and a DEPTH-entry FIFO with valid/ready output. Also exposes the last captured command for display and a one-cycle `new_cmd` pulse.

## Interface
- `DATA_W`, 12, command width in bits (≥1)
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `REPEAT_GAP`, 25_000_000, cycles; an identical command arriving less than this many cycles after the previous capture counts as a repeat
- `DROP_REPEATS`, 1, 1: repeats are not queued; 0: every capture is queued

- `clk`  in  1  system clock; one clock domain, all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  DATA_W  command word from receiver, stable while `in_rdy` is high
- `in_rdy`  in  1  receiver ready level; may stay high for many cycles
- `out_data`  out  DATA_W  FIFO head; 0 when empty
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer pop; a pop occurs when `out_valid && out_ready`
- `new_cmd`  out  1  one-cycle pulse per accepted (queued) command
- `last_cmd`  out  DATA_W  most recent captured command, dropped repeats included
- `count`  out  $clog2(DEPTH+1)  occupied entries
- `overflow`  out  1  sticky; set when an accepted command finds the FIFO full with no pop

## Operation
- Edge detect: `cap = in_rdy && !rdy_q`; `rdy_q <= in_rdy` each cycle. `rdy_q` resets to 1, so a level already high at reset release is never captured.
- Gap counter `gap`: resets to REPEAT_GAP (saturated). Cleared to 0 on every `cap`. Otherwise increments, saturating at REPEAT_GAP.
- Repeat: `rep = DROP_REPEATS && have_last && in_data == last_cmd && gap < REPEAT_GAP`. `have_last` resets to 0 and sets on the first `cap`.
- On `cap`: `last_cmd <= in_data`. Accept iff `!rep`.
- Push of an accepted command:
  - FIFO not full: write at tail.
  - Full with a pop in the same cycle: write succeeds and the head advances. `count` stays DEPTH.
  - Full without a pop: command discarded, `overflow <= 1`, no `new_cmd`.
- `new_cmd <= accepted && written`. `new_cmd` is low in all other cycles.
- Pop: the head pointer advances. A pop while empty is impossible because `out_valid` is low.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately, so full and empty are unambiguous.
- Reset values: `out_valid=0`, `out_data=0`, `new_cmd=0`, `last_cmd=0`, `count=0`, `overflow=0`, pointers 0. `overflow` clears only on `rst`.
- A reset mid-operation discards all queued entries. The repeat history is lost.

## Timing
- Latency: `in_rdy` sampled high at edge N (low at N-1) → at edge N, `last_cmd` and the FIFO are written and `new_cmd` is registered. `out_valid`/`new_cmd` are high in cycle N+1.
- `new_cmd` width is exactly one cycle regardless of `in_rdy` high duration.
- `out_data` is combinational from the head register. It is valid in the same cycle as `out_valid`.
- Pop at edge M: the next entry (or 0 if empty) is presented in cycle M+1.
- Simultaneous push and pop with `count==1`: after the edge, the pushed word is at the head, `count=1`, `out_valid` stays high.
- Empty with push and pop request: no pop occurs. After the edge, `count=1`.
- Back-to-back captures require `in_rdy` to fall for at least one cycle between them.

## Test plan
- Reset with `in_rdy=1`, release, hold high for 10 cycles → no `new_cmd`, `count=0`. Drop, then raise with `in_data=0x0A5` → `new_cmd` for exactly 1 cycle, `out_data=0x0A5`, `out_valid=1` one cycle later.
- DROP_REPEATS=1, REPEAT_GAP=100: send 0x123, then 0x123 again 50 cycles later → second not queued (`count=1`), `last_cmd=0x123`. Third 0x123 150 cycles after the second → queued (`count=2`).
- DROP_REPEATS=0: same stimulus → all three queued, three `new_cmd` pulses.
- DEPTH=4, `out_ready=0`: push 0x001..0x005 → `count=4`, `overflow=1`, head 0x001. Pop all four → 0x001..0x004 in order, then `out_valid=0`, `out_data=0`.
- Full FIFO, capture 0x0FF while `out_ready=1` in the same cycle → `overflow` unchanged, `count=4`, `new_cmd` pulses, 0x0FF ends up last. Covers pointer wrap after 8+ pushes.
- Assert `rst` with `count=3` and `overflow=1` → the next cycle shows all outputs at reset values. A subsequent 0x123 is accepted even if it was the last command before reset.

Source files
------------

// File: rtl/ir_cmd_queue_if.sv
// Handshake bundle between the IR receiver, the command queue and its consumers.
// The slave side is the queue itself; the master side is whoever drives the receiver inputs and pops.
interface ir_cmd_queue_if #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] in_data;
    logic              in_rdy;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              new_cmd;
    logic [DATA_W-1:0] last_cmd;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output in_data, in_rdy, out_ready,
        input  out_data, out_valid, new_cmd, last_cmd, count, overflow
    );

    modport slave (
        input  in_data, in_rdy, out_ready,
        output out_data, out_valid, new_cmd, last_cmd, count, overflow
    );
endinterface

// File: rtl/ir_cmd_queue.sv
// IR command capture: rising-edge detect on in_rdy, optional auto-repeat filter,
// and a DEPTH-entry FIFO with valid/ready output plus last-command and new_cmd outputs.
module ir_cmd_queue #(
    parameter int DATA_W       = 12,
    parameter int DEPTH        = 4,
    parameter int REPEAT_GAP   = 25_000_000,
    parameter int DROP_REPEATS = 1
) (
    input logic            clk,
    input logic            rst,
    ir_cmd_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int GAP_W = $clog2(REPEAT_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(REPEAT_GAP);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic              rdy_q;
    logic              have_last;
    logic [GAP_W-1:0]  gap;
    logic [DATA_W-1:0] last_cmd_r;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    logic              new_cmd_r;

    logic cap;
    logic rep;
    logic accept;
    logic full;
    logic pop;
    logic write;

    always_comb begin
        cap    = bus.in_rdy && !rdy_q;
        rep    = (DROP_REPEATS != 0) && have_last && (bus.in_data == last_cmd_r) && (gap < GAP_MAX);
        accept = cap && !rep;
        full   = (count_r == CNT_FULL);
        pop    = (count_r != '0) && bus.out_ready;
        // A full queue still takes the word when the consumer frees a slot on the same edge.
        write  = accept && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q      <= 1'b1;
            have_last  <= 1'b0;
            gap        <= GAP_MAX;
            last_cmd_r <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            new_cmd_r  <= 1'b0;
        end else begin
            rdy_q <= bus.in_rdy;
            if (cap) begin
                gap        <= '0;
                last_cmd_r <= bus.in_data;
                have_last  <= 1'b1;
            end else if (gap != GAP_MAX) begin
                gap <= gap + 1'b1;
            end
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({write, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (accept && full && !pop) begin
                overflow_r <= 1'b1;
            end
            new_cmd_r <= write;
        end
    end

    // Storage holds data only; stale entries are never visible because out_data is gated by count.
    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    assign bus.out_data  = (count_r != '0) ? mem[rd_ptr] : '0;
    assign bus.out_valid = (count_r != '0);
    assign bus.new_cmd   = new_cmd_r;
    assign bus.last_cmd  = last_cmd_r;
    assign bus.count     = count_r;
    assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_ir_cmd_queue.sv
// Directed bench for ir_cmd_queue: one instance dropping repeats, one queuing everything,
// both fed the same receiver stimulus.
module tb_ir_cmd_queue;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_rdy;
    logic              out_ready;

    int n_chk = 0;
    int n_err = 0;
    int nc_d  = 0;
    int nc_k  = 0;

    ir_cmd_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus_d ();
    ir_cmd_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus_k ();

    assign bus_d.in_data   = in_data;
    assign bus_d.in_rdy    = in_rdy;
    assign bus_d.out_ready = out_ready;
    assign bus_k.in_data   = in_data;
    assign bus_k.in_rdy    = in_rdy;
    assign bus_k.out_ready = out_ready;

    ir_cmd_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REPEAT_GAP(100), .DROP_REPEATS(1)) u_drop (
        .clk (clk),
        .rst (rst),
        .bus (bus_d)
    );

    ir_cmd_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REPEAT_GAP(100), .DROP_REPEATS(0)) u_keep (
        .clk (clk),
        .rst (rst),
        .bus (bus_k)
    );

    always #5 clk = ~clk;

    // Count new_cmd cycles away from the active edge.
    always @(negedge clk) begin
        if (bus_d.new_cmd) nc_d++;
        if (bus_k.new_cmd) nc_k++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        in_data = d;
        in_rdy  = 1'b1;
        tick();
        in_rdy  = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        nc_d = 0;
        nc_k = 0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"},    32'(bus_d.out_valid), 32'd0);
        chk({tag, "_data"},     32'(bus_d.out_data),  32'd0);
        chk({tag, "_new_cmd"},  32'(bus_d.new_cmd),   32'd0);
        chk({tag, "_last_cmd"}, 32'(bus_d.last_cmd),  32'd0);
        chk({tag, "_count"},    32'(bus_d.count),     32'd0);
        chk({tag, "_overflow"}, 32'(bus_d.overflow),  32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_rdy    = 1'b1;
        out_ready = 1'b0;

        // Level high through reset release must not be captured.
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_reset_vals("rst_rel");
        repeat (10) tick();
        chk("hold_high_newcmd", 32'(nc_d), 32'd0);
        chk("hold_high_count",  32'(bus_d.count), 32'd0);
        in_rdy = 1'b0;
        tick();
        in_data = 12'h0A5;
        in_rdy  = 1'b1;
        tick();
        chk("edge_new_cmd",   32'(bus_d.new_cmd),   32'd1);
        chk("edge_out_valid", 32'(bus_d.out_valid), 32'd1);
        chk("edge_out_data",  32'(bus_d.out_data),  32'h0A5);
        tick();
        chk("edge_new_cmd_fall", 32'(bus_d.new_cmd), 32'd0);
        repeat (3) tick();
        in_rdy = 1'b0;
        tick();
        chk("edge_pulse_count", 32'(nc_d), 32'd1);
        pop_one();
        chk("edge_pop_count", 32'(bus_d.count), 32'd0);

        // Repeat filter: 0x123, again after ~50 cycles, again after ~150 cycles.
        do_reset();
        send(12'h123);
        repeat (48) tick();
        send(12'h123);
        chk("rep_drop_count",  32'(bus_d.count),    32'd1);
        chk("rep_drop_last",   32'(bus_d.last_cmd), 32'h123);
        chk("rep_keep_count2", 32'(bus_k.count),    32'd2);
        repeat (148) tick();
        send(12'h123);
        chk("rep_drop_count3", 32'(bus_d.count), 32'd2);
        chk("rep_keep_count3", 32'(bus_k.count), 32'd3);
        chk("rep_drop_pulses", 32'(nc_d), 32'd2);
        chk("rep_keep_pulses", 32'(nc_k), 32'd3);

        // Overflow: five pushes into a four-entry queue, then drain in order.
        do_reset();
        for (int i = 1; i <= 5; i++) send(DATA_W'(i));
        chk("ovf_count",  32'(bus_d.count),    32'd4);
        chk("ovf_flag",   32'(bus_d.overflow), 32'd1);
        chk("ovf_head",   32'(bus_d.out_data), 32'h001);
        chk("ovf_pulses", 32'(nc_d),           32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", 32'(bus_d.out_valid), 32'd1);
            chk("drain_data",  32'(bus_d.out_data),  32'(i));
            pop_one();
        end
        chk("drained_valid",    32'(bus_d.out_valid), 32'd0);
        chk("drained_data",     32'(bus_d.out_data),  32'd0);
        chk("drained_overflow", 32'(bus_d.overflow),  32'd1);

        // Full queue with a push and pop on the same edge, after pointer wrap.
        do_reset();
        for (int i = 0; i < 4; i++) send(12'h010 + DATA_W'(i));
        pop_one();
        pop_one();
        send(12'h014);
        send(12'h015);
        chk("wrap_count", 32'(bus_d.count),    32'd4);
        chk("wrap_head",  32'(bus_d.out_data), 32'h012);
        pop_one();
        send(12'h016);
        chk("wrap2_count", 32'(bus_d.count), 32'd4);
        in_data   = 12'h0FF;
        in_rdy    = 1'b1;
        out_ready = 1'b1;
        tick();
        in_rdy    = 1'b0;
        out_ready = 1'b0;
        chk("fullpp_new_cmd",  32'(bus_d.new_cmd),  32'd1);
        chk("fullpp_count",    32'(bus_d.count),    32'd4);
        chk("fullpp_overflow", 32'(bus_d.overflow), 32'd0);
        chk("fullpp_head",     32'(bus_d.out_data), 32'h014);
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [DATA_W-1:0] exp_v [4];
            exp_v = '{12'h014, 12'h015, 12'h016, 12'h0FF};
            chk("fullpp_drain", 32'(bus_d.out_data), 32'(exp_v[i]));
            pop_one();
        end
        chk("fullpp_empty", 32'(bus_d.out_valid), 32'd0);

        // Reset mid-operation with count=3 and overflow set; repeat history is lost.
        do_reset();
        send(12'h021);
        send(12'h022);
        send(12'h023);
        send(12'h024);
        send(12'h123);
        pop_one();
        chk("mid_count",    32'(bus_d.count),    32'd3);
        chk("mid_overflow", 32'(bus_d.overflow), 32'd1);
        chk("mid_last",     32'(bus_d.last_cmd), 32'h123);
        rst = 1'b1;
        tick();
        chk_reset_vals("mid_rst");
        rst = 1'b0;
        tick();
        nc_d = 0;
        send(12'h123);
        chk("post_rst_count",  32'(bus_d.count),    32'd1);
        chk("post_rst_data",   32'(bus_d.out_data), 32'h123);
        chk("post_rst_pulses", 32'(nc_d),           32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
